hu_audiodec_load_dma32: RTL and testbench
=========================================

Name: hu_audiodec_load_dma32

Overview:
- Input-load stage directly upstream of the audio-decoder compute core in the 32-bit-DMA accelerator wrapper.
- On conf_done it fetches the configured number of 32-bit input words from memory over the ESP DMA read interface, split into bursts.
- It buffers the words in a local FIFO and presents them to the decoder core on a valid/ready stream.
- It signals load_done once every word has been handed to the decoder core.

Parameters:
- BURST_MAX, 16, maximum words per DMA read request (power of two, ≥1)
- FIFO_DEPTH, 32, buffer depth in words (power of two, ≥ BURST_MAX)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- conf_done  in  1  one-cycle start pulse; configuration is valid in the same cycle
- cfg_in_offset  in  32  word index of the first input word
- cfg_in_words  in  32  total input words to load
- dma_read_ctrl_valid  out  1  read request valid
- dma_read_ctrl_ready  in  1  read request accepted
- dma_read_ctrl_data_index  out  32  word index of burst start
- dma_read_ctrl_data_length  out  32  burst length in words
- dma_read_ctrl_data_size  out  3  beat size, constant 3'b010 (32-bit)
- dma_read_chnl_valid  in  1  read data beat valid
- dma_read_chnl_ready  out  1  read data beat accepted
- dma_read_chnl_data  in  32  read data beat
- out_valid  out  1  word available to decoder core
- out_ready  in  1  decoder core accepts word
- out_data  out  32  word to decoder core
- load_done  out  1  one-cycle pulse, all words delivered
- debug  out  32  {26'd0, err_restart, 2'd0, state[2:0]}

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; all counters and the FIFO cleared
  - dma_read_ctrl_valid, dma_read_chnl_ready, out_valid, load_done = 0
  - index/length = 0; err_restart = 0
- On conf_done in IDLE, latch offset and words into internal registers:
  - req_cnt = 0 (words requested)
  - rcv_cnt = 0 (words received)
  - out_cnt = 0 (words delivered)
  - if words == 0, go directly to DONE
- States: IDLE, REQ, XFER, DRAIN, DONE.
- IDLE → REQ on conf_done with words > 0.
- REQ:
  - burst = min(BURST_MAX, words − req_cnt)
  - ctrl_valid asserts only when FIFO free slots ≥ burst; index = offset + req_cnt; length = burst
  - valid, index and length are held stable until ready
  - on valid&&ready: req_cnt += burst, beats_left = burst, → XFER
- XFER:
  - dma_read_chnl_ready = (FIFO not full), combinational on registered FIFO count
  - each valid&&ready beat pushes data into the FIFO and decrements beats_left
  - on the last beat: → REQ if req_cnt < words, else → DRAIN
- Output stream (active in REQ, XFER and DRAIN):
  - out_valid = FIFO not empty; out_data = FIFO head (first-word-fall-through)
  - pop on out_valid&&out_ready; out_cnt increments per pop
- DRAIN → DONE when out_cnt == words, i.e. FIFO empty and all received.
- DONE: load_done = 1 for exactly one cycle, then → IDLE.
- Latency: the first word is visible on out_data the cycle after its chnl beat is accepted.
- Simultaneous push and pop: FIFO count unchanged; the pop is allowed when full only if a push is not also accepted that cycle. chnl_ready is already 0 when full, so no conflict arises.
- conf_done outside IDLE: ignored, err_restart set sticky until reset.
- Arithmetic: all counters 32-bit unsigned; index addition wraps modulo 2^32 without flagging.
- No request is issued while a burst's beats are still outstanding; there is exactly one request in flight at a time.
- A chnl beat arriving in a non-XFER state is not accepted (ready = 0).

Test Plan:
- words=0, conf_done → no ctrl_valid ever; load_done pulses exactly 2 cycles after conf_done; debug state returns to IDLE.
- offset=0x100, words=40, BURST_MAX=16, out_ready held 1 → requests (0x100,16), (0x110,16), (0x120,8); 40 words out in order matching memory; single load_done pulse.
- words=40, out_ready=0 throughout → FIFO fills to 32; third request withheld (free < 8); chnl_ready drops at full; release out_ready → transfer completes, data order intact.
- dma_read_ctrl_ready delayed 5 cycles and random chnl_valid/out_ready gaps → index/length stable while valid is unacknowledged; no words lost or duplicated across 1000 random words.
- conf_done pulsed mid-XFER → ignored; current job completes normally; debug bit 5 = 1.
- rst deasserted→asserted low mid-XFER → all outputs 0 immediately (async); a new conf_done after release runs a fresh job correctly.

Source files
------------

// File: rtl/hu_audiodec_load_dma32.sv
// ---------------------------------------------------------------------------
// hu_audiodec_load_dma32
//
// Input-load stage for the audio-decoder core. It starts on conf_done and
// reads cfg_in_words 32-bit words, beginning at word index cfg_in_offset, over
// the ESP DMA read interface. Reads are split into bursts of at most
// BURST_MAX words. The words are buffered in a local first-word-fall-through
// FIFO and handed to the decoder core on a valid/ready stream. load_done
// pulses for one cycle once every word has been delivered.
//
// Ports
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   conf_done                  one-cycle start pulse, qualifies cfg_in_*
//   cfg_in_offset/words        first word index / number of words to load
//   dma_read_ctrl_*            burst request (index, length, size=32-bit)
//   dma_read_chnl_*            read data beats
//   out_valid/ready/data       word stream to the decoder core
//   load_done                  one-cycle pulse, whole job delivered
//   debug                      {26'd0, err_restart, 2'd0, state[2:0]}
// ---------------------------------------------------------------------------
module hu_audiodec_load_dma32 #(
  parameter int BURST_MAX  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        conf_done,
  input  logic [31:0] cfg_in_offset,
  input  logic [31:0] cfg_in_words,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [31:0] dma_read_chnl_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        load_done,
  output logic [31:0] debug
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]   BURST_W  = 32'(BURST_MAX);
  localparam logic [31:0]   DEPTH_W  = 32'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, next_state;
  logic [31:0]   offset_q, words_q;
  logic [31:0]   req_cnt, rcv_cnt, out_cnt, beats_left;
  logic          err_restart;
  logic          load_done_q;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic [31:0]   remaining, burst, free_slots;
  logic          fifo_full, fifo_empty, stream_active;
  logic          push, pop, req_fire;

  assign remaining  = words_q - req_cnt;
  assign burst      = (remaining < BURST_W) ? remaining : BURST_W;
  assign free_slots = DEPTH_W - 32'(fifo_cnt);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // The stream side keeps running while requests and beats are in flight,
  // so the decoder can start consuming as soon as the first word lands.
  assign stream_active = (state == REQ) || (state == XFER) || (state == DRAIN);

  assign push     = dma_read_chnl_valid && dma_read_chnl_ready;
  assign pop      = out_valid && out_ready;
  assign req_fire = dma_read_ctrl_valid && dma_read_ctrl_ready;

  assign out_valid = stream_active && !fifo_empty;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 32'd0;

  assign dma_read_ctrl_data_size = 3'b010;
  assign load_done = load_done_q;
  assign debug     = {26'd0, err_restart, 2'd0, state};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. A request is only raised once the
  // whole burst fits in the FIFO, so an accepted burst can never stall the
  // DMA channel. Nothing in REQ pushes into the FIFO, so free space only grows
  // there and valid/index/length stay stable until the request is taken.
  always_comb begin
    next_state                = state;
    dma_read_ctrl_valid       = 1'b0;
    dma_read_ctrl_data_index  = 32'd0;
    dma_read_ctrl_data_length = 32'd0;
    dma_read_chnl_ready       = 1'b0;
    case (state)
      IDLE: begin
        if (conf_done) begin
          next_state = (cfg_in_words == 32'd0) ? DONE : REQ;
        end
      end
      REQ: begin
        dma_read_ctrl_data_index  = offset_q + req_cnt;
        dma_read_ctrl_data_length = burst;
        dma_read_ctrl_valid       = (free_slots >= burst);
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          next_state = XFER;
        end
      end
      XFER: begin
        dma_read_chnl_ready = !fifo_full;
        if (push && (beats_left == 32'd1)) begin
          next_state = (req_cnt < words_q) ? REQ : DRAIN;
        end
      end
      DRAIN: begin
        if ((out_cnt == words_q) && (rcv_cnt == words_q)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Job bookkeeping. A conf_done arriving mid-job is dropped, but it leaves
  // a sticky flag behind so firmware can see that it lost a start request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_q    <= 32'd0;
      words_q     <= 32'd0;
      req_cnt     <= 32'd0;
      rcv_cnt     <= 32'd0;
      out_cnt     <= 32'd0;
      beats_left  <= 32'd0;
      err_restart <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= (state == DONE);
      if (conf_done) begin
        if (state == IDLE) begin
          offset_q <= cfg_in_offset;
          words_q  <= cfg_in_words;
          req_cnt  <= 32'd0;
          rcv_cnt  <= 32'd0;
          out_cnt  <= 32'd0;
        end else begin
          err_restart <= 1'b1;
        end
      end
      if (req_fire) begin
        req_cnt    <= req_cnt + burst;
        beats_left <= burst;
      end
      if (push) begin
        rcv_cnt    <= rcv_cnt + 32'd1;
        beats_left <= beats_left - 32'd1;
      end
      if (pop) begin
        out_cnt <= out_cnt + 32'd1;
      end
    end
  end

  // FIFO storage has no reset; the pointers and count below define
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= dma_read_chnl_data;
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the
  // count unchanged. Push is never offered while full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_hu_audiodec_load_dma32.sv
// ---------------------------------------------------------------------------
// tb_hu_audiodec_load_dma32
//
// Directed bench for the load DMA stage. A memory/DMA responder returns
// word (0xCAFE0000 + index) for every index requested. A sink collects the
// delivered stream. The main sequence runs a table of jobs and then
// hand-written corner cases: a zero-length job, FIFO back-pressure, a restart
// mid-transfer and an asynchronous reset mid-transfer.
// ---------------------------------------------------------------------------
module tb_hu_audiodec_load_dma32;

  logic        clk;
  logic        rst;
  logic        conf_done;
  logic [31:0] cfg_in_offset, cfg_in_words;
  logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid, dma_read_chnl_ready;
  logic [31:0] dma_read_chnl_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        load_done;
  logic [31:0] debug;

  hu_audiodec_load_dma32 #(.BURST_MAX(16), .FIFO_DEPTH(32)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .conf_done                (conf_done),
    .cfg_in_offset            (cfg_in_offset),
    .cfg_in_words             (cfg_in_words),
    .dma_read_ctrl_valid      (dma_read_ctrl_valid),
    .dma_read_ctrl_ready      (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size  (dma_read_ctrl_data_size),
    .dma_read_chnl_valid      (dma_read_chnl_valid),
    .dma_read_chnl_ready      (dma_read_chnl_ready),
    .dma_read_chnl_data       (dma_read_chnl_data),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .out_data                 (out_data),
    .load_done                (load_done),
    .debug                    (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Job settings written by the main sequence, read by the responder.
  int          job_gen = 0;
  int          job_ctrl_delay = 0;
  int          job_rand = 0;
  int          sink_mode = 0;

  // Responder state and logs, written only by the responder process.
  int          seen_gen = 0;
  logic [31:0] got_q[$];
  logic [31:0] req_idx_q[$];
  logic [31:0] req_len_q[$];
  logic [31:0] next_idx = 0;
  logic [31:0] beats_rem = 0;
  int          ctrl_wait = 0;
  logic        held = 1'b0;
  logic [31:0] held_idx = 0, held_len = 0;
  int          stab_viol = 0;
  int          overlap_viol = 0;
  int          done_pulses = 0;

  typedef struct {
    logic [31:0] offset;
    logic [31:0] words;
    int          ctrl_delay;
    int          rand_mode;
    int          sink;
    int          exp_reqs;
    logic [31:0] exp_last_len;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return 32'hCAFE_0000 + idx;
  endfunction

  // DMA responder and stream sink. Everything happens on the falling edge:
  // outputs are sampled, inputs for the next rising edge are driven, and
  // handshakes that will complete on that edge are logged.
  initial begin
    dma_read_ctrl_ready = 1'b0;
    dma_read_chnl_valid = 1'b0;
    dma_read_chnl_data  = 32'd0;
    out_ready           = 1'b0;
    forever begin
      @(negedge clk);
      if (job_gen != seen_gen) begin
        seen_gen = job_gen;
        got_q.delete();
        req_idx_q.delete();
        req_len_q.delete();
        beats_rem    = 0;
        ctrl_wait    = 0;
        held         = 1'b0;
        stab_viol    = 0;
        overlap_viol = 0;
        done_pulses  = 0;
      end
      if (dma_read_ctrl_valid) begin
        if (held && (dma_read_ctrl_data_index != held_idx ||
                     dma_read_ctrl_data_length != held_len)) begin
          stab_viol = stab_viol + 1;
        end
        if (!held) begin
          held      = 1'b1;
          held_idx  = dma_read_ctrl_data_index;
          held_len  = dma_read_ctrl_data_length;
          ctrl_wait = 0;
        end
        if (ctrl_wait >= job_ctrl_delay) begin
          dma_read_ctrl_ready = 1'b1;
          if (beats_rem != 0) overlap_viol = overlap_viol + 1;
          req_idx_q.push_back(dma_read_ctrl_data_index);
          req_len_q.push_back(dma_read_ctrl_data_length);
          beats_rem = dma_read_ctrl_data_length;
          next_idx  = dma_read_ctrl_data_index;
          held      = 1'b0;
        end else begin
          dma_read_ctrl_ready = 1'b0;
          ctrl_wait = ctrl_wait + 1;
        end
      end else begin
        if (held) stab_viol = stab_viol + 1;
        held = 1'b0;
        dma_read_ctrl_ready = 1'b0;
      end
      if (beats_rem != 0 && (job_rand == 0 || $urandom_range(0, 3) != 0)) begin
        dma_read_chnl_valid = 1'b1;
        dma_read_chnl_data  = mem_word(next_idx);
      end else begin
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = 32'hDEAD_BEEF;
      end
      if (dma_read_chnl_valid && dma_read_chnl_ready) begin
        next_idx  = next_idx + 32'd1;
        beats_rem = beats_rem - 32'd1;
      end
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (load_done) done_pulses = done_pulses + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] offset, input logic [31:0] words);
    @(negedge clk);
    job_gen       = job_gen + 1;
    cfg_in_offset = offset;
    cfg_in_words  = words;
    conf_done     = 1'b1;
    @(negedge clk);
    conf_done     = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (done_pulses == 0 && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("load_done within budget", 32'(done_pulses != 0), 32'd1);
  endtask

  task automatic waitXfer();
    int n;
    n = 0;
    while (debug[2:0] != 3'd2 && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("reached XFER", {29'd0, debug[2:0]}, 32'd2);
  endtask

  // Compare everything the responder logged against the expected job.
  task automatic verifyJob(input logic [31:0] offset, input logic [31:0] words,
                           input int exp_reqs, input logic [31:0] exp_last_len);
    logic [31:0] left, exp_len;
    int n;
    repeat (5) @(negedge clk);
    checkOutput("load_done pulse count", 32'(done_pulses), 32'd1);
    checkOutput("words delivered", 32'(got_q.size()), words);
    n = (got_q.size() < int'(words)) ? got_q.size() : int'(words);
    for (int i = 0; i < n; i++) begin
      checkOutput("out_data word", got_q[i], mem_word(offset + 32'(i)));
    end
    checkOutput("request count", 32'(req_idx_q.size()), 32'(exp_reqs));
    left = words;
    n = (req_idx_q.size() < exp_reqs) ? req_idx_q.size() : exp_reqs;
    for (int k = 0; k < n; k++) begin
      exp_len = (left < 32'd16) ? left : 32'd16;
      checkOutput("request index", req_idx_q[k], offset + 32'(16 * k));
      checkOutput("request length", req_len_q[k], exp_len);
      left = left - exp_len;
    end
    if (exp_reqs > 0 && req_len_q.size() > 0) begin
      checkOutput("last request length", req_len_q[req_len_q.size() - 1], exp_last_len);
    end
    checkOutput("ctrl stable while pending", 32'(stab_viol), 32'd0);
    checkOutput("single request in flight", 32'(overlap_viol), 32'd0);
    checkOutput("state back to IDLE", {29'd0, debug[2:0]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b0;
    conf_done     = 1'b0;
    cfg_in_offset = 32'd0;
    cfg_in_words  = 32'd0;

    vecs[0] = '{32'h0000_0100, 32'd40,   0, 0, 0, 3,  32'd8};
    vecs[1] = '{32'h0000_0000, 32'd1,    0, 0, 0, 1,  32'd1};
    vecs[2] = '{32'hFFFF_FFF8, 32'd20,   1, 0, 0, 2,  32'd4};
    vecs[3] = '{32'h0000_2000, 32'd16,   0, 0, 1, 1,  32'd16};
    vecs[4] = '{32'h0000_0040, 32'd1000, 5, 1, 1, 63, 32'd8};
    vecs[5] = '{32'h0000_1234, 32'd0,    0, 0, 0, 0,  32'd0};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset ctrl_valid", {31'd0, dma_read_ctrl_valid}, 32'd0);
    checkOutput("reset chnl_ready", {31'd0, dma_read_chnl_ready}, 32'd0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset load_done", {31'd0, load_done}, 32'd0);
    checkOutput("reset index", dma_read_ctrl_data_index, 32'd0);
    checkOutput("reset length", dma_read_ctrl_data_length, 32'd0);
    checkOutput("reset debug", debug, 32'd0);
    checkOutput("ctrl size", {29'd0, dma_read_ctrl_data_size}, 32'd2);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table of jobs.
    for (int v = 0; v < 6; v++) begin
      $display("[TB] job %0d: offset=0x%08h words=%0d", v, vecs[v].offset, vecs[v].words);
      job_ctrl_delay = vecs[v].ctrl_delay;
      job_rand       = vecs[v].rand_mode;
      sink_mode      = vecs[v].sink;
      applyStimulus(vecs[v].offset, vecs[v].words);
      waitDone(20000);
      verifyJob(vecs[v].offset, vecs[v].words, vecs[v].exp_reqs, vecs[v].exp_last_len);
    end

    // Zero-length job: DONE one cycle after conf_done, load_done the next.
    job_ctrl_delay = 0;
    job_rand       = 0;
    sink_mode      = 0;
    applyStimulus(32'h0000_0055, 32'd0);
    checkOutput("zero job state DONE", {29'd0, debug[2:0]}, 32'd4);
    checkOutput("zero job no pulse yet", {31'd0, load_done}, 32'd0);
    checkOutput("zero job no ctrl_valid", {31'd0, dma_read_ctrl_valid}, 32'd0);
    @(negedge clk);
    checkOutput("zero job load_done", {31'd0, load_done}, 32'd1);
    checkOutput("zero job back to IDLE", {29'd0, debug[2:0]}, 32'd0);
    checkOutput("zero job no ctrl_valid late", {31'd0, dma_read_ctrl_valid}, 32'd0);
    @(negedge clk);
    checkOutput("zero job pulse width", {31'd0, load_done}, 32'd0);

    // Back-pressure: consumer stalled, FIFO fills and the third request waits.
    sink_mode = 2;
    applyStimulus(32'h0000_0100, 32'd40);
    repeat (150) @(negedge clk);
    checkOutput("stalled request count", 32'(req_idx_q.size()), 32'd2);
    checkOutput("stalled state REQ", {29'd0, debug[2:0]}, 32'd1);
    checkOutput("stalled ctrl_valid withheld", {31'd0, dma_read_ctrl_valid}, 32'd0);
    checkOutput("stalled chnl_ready", {31'd0, dma_read_chnl_ready}, 32'd0);
    checkOutput("stalled out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("stalled head word", out_data, mem_word(32'h0000_0100));
    sink_mode = 0;
    waitDone(2000);
    verifyJob(32'h0000_0100, 32'd40, 3, 32'd8);

    // conf_done mid-transfer is ignored and flagged.
    applyStimulus(32'h0000_0500, 32'd40);
    waitXfer();
    cfg_in_offset = 32'h0000_0999;
    cfg_in_words  = 32'd5;
    conf_done     = 1'b1;
    @(negedge clk);
    conf_done     = 1'b0;
    waitDone(2000);
    verifyJob(32'h0000_0500, 32'd40, 3, 32'd8);
    checkOutput("err_restart sticky", debug, 32'h0000_0020);

    // Asynchronous reset mid-transfer, then a fresh job.
    applyStimulus(32'h0000_0700, 32'd40);
    waitXfer();
    #2;
    rst = 1'b0;
    job_gen = job_gen + 1;
    #1;
    checkOutput("async rst ctrl_valid", {31'd0, dma_read_ctrl_valid}, 32'd0);
    checkOutput("async rst chnl_ready", {31'd0, dma_read_chnl_ready}, 32'd0);
    checkOutput("async rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async rst out_data", out_data, 32'd0);
    checkOutput("async rst load_done", {31'd0, load_done}, 32'd0);
    checkOutput("async rst debug", debug, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0000_0300, 32'd20);
    waitDone(2000);
    verifyJob(32'h0000_0300, 32'd20, 2, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
